// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the 7-segment scan driver.
// Patterns are g..a, active-low (bit 6 = g, bit 0 = a).
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner with double-buffered updates,
// leading-zero blanking, per-digit decimal points, PWM dimming and a dead cycle per slot.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int SLOT_CYCLES = 50000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]       slot_cnt;
    logic [DIG_W-1:0]        dig_idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic                    pend;

    logic                    slot_wrap;
    logic                    frame_end;
    logic                    lit;
    logic [3:0]              nib [NUM_DIGITS];
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [NUM_DIGITS-1:0]   lz_mask;
    seg7_t                   dec_seg;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_wrap && (dig_idx == DIG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (slot_wrap) begin
                slot_cnt <= '0;
                dig_idx  <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    // A load in the boundary cycle lands after the transfer, so pend stays set
    // and the new data waits for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend       <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
        end else begin
            if (frame_end && pend) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                pend      <= 1'b0;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend       <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = act_value[4*gi +: 4];
        end
    endgenerate

    // zero_from[i]: nibbles i..NUM_DIGITS-1 are all zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run          = run && (act_value[4*i +: 4] == 4'h0);
            zero_from[i] = run;
        end
    end

    assign lz_mask = zero_from & {NUM_DIGITS{lz_blank}} & ~NUM_DIGITS'(1);
    assign cur_nib = nib[dig_idx];
    assign lit     = (slot_cnt != '0) && (pwm_cnt <= bright);

    seg7_hex_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_BLANK;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (slot_cnt == '0) && (dig_idx == '0);
            if (lit) begin
                an_n <= ~(NUM_DIGITS'(1) << dig_idx);
                seg  <= lz_mask[dig_idx] ? SEG_BLANK : dec_seg;
                dp_n <= ~act_dp[dig_idx];
            end else begin
                an_n <= '1;
                seg  <= SEG_BLANK;
                dp_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with 4 digits, 4-cycle slots, 2-bit brightness.
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [4*N-1:0] value;
    logic [N-1:0]  dp_in;
    logic          lz_blank;
    logic [BW-1:0] bright;
    logic [6:0]    seg;
    logic          dp_n;
    logic [N-1:0]  an_n;
    logic          frame_start;

    int n_cmp = 0;
    int n_err = 0;
    int ph    = 0;   // posedges since reset release; outputs show counter state ph-1

    seg7_scan_driver #(.NUM_DIGITS(N), .SLOT_CYCLES(S), .BRIGHT_W(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .lz_blank    (lz_blank),
        .bright      (bright),
        .seg         (seg),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        ph++;
    endtask

    task automatic test_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fs;
        int st, slot, dig;
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b0; bright = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got=%b exp=%b", seg, 7'h7F); end
        n_cmp++; if (an_n !== 4'hF) begin n_err++; $display("FAIL reset_an got=%b exp=1111", an_n); end
        n_cmp++; if (dp_n !== 1'b1) begin n_err++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        #2 rst_n = 1'b1;
        ph = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            st = ph - 1; slot = st % S; dig = (st / S) % N;
            exp_an  = (slot != 0) ? ~(4'b0001 << dig) : 4'b1111;
            exp_seg = (slot != 0) ? 7'b1000000 : 7'b1111111;
            exp_fs  = (st % 16 == 0);
            n_cmp++; if (an_n !== exp_an) begin n_err++; $display("FAIL first_an st=%0d got=%b exp=%b", st, an_n, exp_an); end
            n_cmp++; if (seg !== exp_seg) begin n_err++; $display("FAIL first_seg st=%0d got=%b exp=%b", st, seg, exp_seg); end
            n_cmp++; if (frame_start !== exp_fs) begin n_err++; $display("FAIL first_fs st=%0d got=%b exp=%b", st, frame_start, exp_fs); end
            n_cmp++; if (dp_n !== 1'b1) begin n_err++; $display("FAIL first_dp st=%0d got=%b exp=1", st, dp_n); end
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] pat [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int st, slot, dig;
        pat[0] = 7'b0000000; pat[1] = 7'b0001110; pat[2] = 7'b0010010; pat[3] = 7'b0001000;
        while (ph < 37) tick();
        value = 16'hA5F8; load = 1'b1;
        tick();
        load = 1'b0;
        while (ph < 64) begin
            tick();
            st = ph - 1; slot = st % S; dig = (st / S) % N;
            exp_an  = (slot != 0) ? ~(4'b0001 << dig) : 4'b1111;
            exp_seg = (slot == 0) ? 7'b1111111 : (st < 48) ? 7'b1000000 : pat[dig];
            n_cmp++; if (an_n !== exp_an) begin n_err++; $display("FAIL tear_an st=%0d got=%b exp=%b", st, an_n, exp_an); end
            n_cmp++; if (seg !== exp_seg) begin n_err++; $display("FAIL tear_seg st=%0d got=%b exp=%b", st, seg, exp_seg); end
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] pat_a [4];
        logic [6:0] pat_b [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int st, slot, dig;
        pat_a[0] = 7'b1000000; pat_a[1] = 7'b0110000; pat_a[2] = 7'b1111111; pat_a[3] = 7'b1111111;
        pat_b[0] = 7'b1000000; pat_b[1] = 7'b1111111; pat_b[2] = 7'b1111111; pat_b[3] = 7'b1111111;
        value = 16'h0030; lz_blank = 1'b1; load = 1'b1;
        tick();
        while (ph < 112) begin
            load = (ph == 85);
            if (ph == 85) value = 16'h0000;
            tick();
            st = ph - 1; slot = st % S; dig = (st / S) % N;
            if (st >= 80) begin
                exp_an  = (slot != 0) ? ~(4'b0001 << dig) : 4'b1111;
                exp_seg = (slot == 0) ? 7'b1111111 : (st < 96) ? pat_a[dig] : pat_b[dig];
                n_cmp++; if (an_n !== exp_an) begin n_err++; $display("FAIL lz_an st=%0d got=%b exp=%b", st, an_n, exp_an); end
                n_cmp++; if (seg !== exp_seg) begin n_err++; $display("FAIL lz_seg st=%0d got=%b exp=%b", st, seg, exp_seg); end
            end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] pat_x [4];
        logic [6:0] pat_y [4];
        logic [6:0] exp_seg;
        logic       exp_fs;
        int st, slot, dig;
        pat_x[0] = 7'b0011001; pat_x[1] = 7'b0110000; pat_x[2] = 7'b0100100; pat_x[3] = 7'b1111001;
        pat_y[0] = 7'b0000011; pat_y[1] = 7'b0000110; pat_y[2] = 7'b0100001; pat_y[3] = 7'b1000110;
        lz_blank = 1'b0;
        while (ph < 126) tick();
        value = 16'h1234; load = 1'b1;
        tick();
        value = 16'hCDEB;
        tick();
        load = 1'b0;
        while (ph < 160) begin
            tick();
            st = ph - 1; slot = st % S; dig = (st / S) % N;
            exp_seg = (slot == 0) ? 7'b1111111 : (st < 144) ? pat_x[dig] : pat_y[dig];
            exp_fs  = (st % 16 == 0);
            n_cmp++; if (seg !== exp_seg) begin n_err++; $display("FAIL race_seg st=%0d got=%b exp=%b", st, seg, exp_seg); end
            n_cmp++; if (frame_start !== exp_fs) begin n_err++; $display("FAIL race_fs st=%0d got=%b exp=%b", st, frame_start, exp_fs); end
        end
    endtask

    task automatic test_brightness();
        logic [6:0] pat [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic       lit;
        int st, slot, dig, b;
        pat[0] = 7'b0000010; pat[1] = 7'b1111000; pat[2] = 7'b0000000; pat[3] = 7'b0010000;
        value = 16'h9876; dp_in = 4'b0100; bright = 2'd0; load = 1'b1;
        tick();
        load = 1'b0; dp_in = 4'b0000;
        while (ph < 224) begin
            b = (ph < 192) ? 0 : (ph < 208) ? 1 : 2;
            bright = BW'(b);
            tick();
            st = ph - 1; slot = st % S; dig = (st / S) % N;
            // pwm_cnt and slot_cnt both start at 0 with period 4, so pwm_cnt == slot here.
            lit     = (slot != 0) && (slot <= b);
            exp_an  = lit ? ~(4'b0001 << dig) : 4'b1111;
            exp_seg = lit ? pat[dig] : 7'b1111111;
            exp_dp  = !(lit && dig == 2);
            n_cmp++; if (an_n !== exp_an) begin n_err++; $display("FAIL bright_an st=%0d got=%b exp=%b", st, an_n, exp_an); end
            n_cmp++; if (seg !== exp_seg) begin n_err++; $display("FAIL bright_seg st=%0d got=%b exp=%b", st, seg, exp_seg); end
            n_cmp++; if (dp_n !== exp_dp) begin n_err++; $display("FAIL bright_dp st=%0d got=%b exp=%b", st, dp_n, exp_dp); end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fs;
        int st, slot, dig;
        bright = 2'd3;
        while (ph < 226) tick();
        value = 16'h5555; load = 1'b1;
        tick();
        load = 1'b0;
        while (ph < 235) tick();
        n_cmp++; if (an_n !== 4'b1011) begin n_err++; $display("FAIL midrst_pre_an got=%b exp=1011", an_n); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (seg !== 7'h7F) begin n_err++; $display("FAIL midrst_seg got=%b exp=1111111", seg); end
        n_cmp++; if (an_n !== 4'hF) begin n_err++; $display("FAIL midrst_an got=%b exp=1111", an_n); end
        n_cmp++; if (dp_n !== 1'b1) begin n_err++; $display("FAIL midrst_dp got=%b exp=1", dp_n); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL midrst_fs got=%b exp=0", frame_start); end
        @(posedge clk);
        #1;
        n_cmp++; if (an_n !== 4'hF) begin n_err++; $display("FAIL midrst_hold_an got=%b exp=1111", an_n); end
        #2 rst_n = 1'b1;
        ph = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            st = ph - 1; slot = st % S; dig = (st / S) % N;
            exp_an  = (slot != 0) ? ~(4'b0001 << dig) : 4'b1111;
            exp_seg = (slot != 0) ? 7'b1000000 : 7'b1111111;
            exp_fs  = (st % 16 == 0);
            n_cmp++; if (an_n !== exp_an) begin n_err++; $display("FAIL postrst_an st=%0d got=%b exp=%b", st, an_n, exp_an); end
            n_cmp++; if (seg !== exp_seg) begin n_err++; $display("FAIL postrst_seg st=%0d got=%b exp=%b", st, seg, exp_seg); end
            n_cmp++; if (frame_start !== exp_fs) begin n_err++; $display("FAIL postrst_fs st=%0d got=%b exp=%b", st, frame_start, exp_fs); end
        end
    endtask

    initial begin
        test_reset();
        $display("test_reset done: ph=%0d compared=%0d", ph, n_cmp);
        test_tear_free();
        $display("test_tear_free done: ph=%0d compared=%0d", ph, n_cmp);
        test_lz_blank();
        $display("test_lz_blank done: ph=%0d compared=%0d", ph, n_cmp);
        test_back_to_back();
        $display("test_back_to_back done: ph=%0d compared=%0d", ph, n_cmp);
        test_brightness();
        $display("test_brightness done: ph=%0d compared=%0d", ph, n_cmp);
        test_mid_reset();
        $display("test_mid_reset done: ph=%0d compared=%0d", ph, n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
